// File: rtl/corner_pkg.sv
// ============================================================================
// Module : corner_pkg
// Shared types and encodings for the corner detection and tracking stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package corner_pkg;

  typedef logic [9:0] coord_t;

  localparam int NUM_COORDS = 8;

  localparam logic [2:0] IDX_TL_X = 3'd0;
  localparam logic [2:0] IDX_TL_Y = 3'd1;
  localparam logic [2:0] IDX_TR_X = 3'd2;
  localparam logic [2:0] IDX_TR_Y = 3'd3;
  localparam logic [2:0] IDX_BL_X = 3'd4;
  localparam logic [2:0] IDX_BL_Y = 3'd5;
  localparam logic [2:0] IDX_BR_X = 3'd6;
  localparam logic [2:0] IDX_BR_Y = 3'd7;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_FILTER  = 2'd3
  } fsm_state_e;

  typedef enum logic [1:0] {
    TRK_SEARCH = 2'd0,
    TRK_TRACK  = 2'd1
  } track_state_e;

  // Pixel classification codes emitted by the colour/corner detector.
  typedef enum logic [2:0] {
    CC_NONE         = 3'd0,
    CC_TOP_LEFT     = 3'd1,
    CC_TOP_RIGHT    = 3'd2,
    CC_BOTTOM_LEFT  = 3'd3,
    CC_BOTTOM_RIGHT = 3'd4,
    CC_GREEN        = 3'd5
  } corner_code_e;

endpackage

`default_nettype wire

// File: rtl/corner_tracker_if.sv
// ============================================================================
// Module : corner_tracker_if
// Result handshake bus from the corner tracker to the overlay/HPS consumer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface corner_tracker_if;
  import corner_pkg::*;

  logic   out_valid;
  logic   out_ready;
  coord_t f_tl_x;
  coord_t f_tl_y;
  coord_t f_tr_x;
  coord_t f_tr_y;
  coord_t f_bl_x;
  coord_t f_bl_y;
  coord_t f_br_x;
  coord_t f_br_y;

  modport master (
    output out_valid,
    output f_tl_x, f_tl_y, f_tr_x, f_tr_y, f_bl_x, f_bl_y, f_br_x, f_br_y,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  f_tl_x, f_tl_y, f_tr_x, f_tr_y, f_bl_x, f_bl_y, f_br_x, f_br_y,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/corner_ema.sv
// ============================================================================
// Module : corner_ema
// Combinational single-coordinate EMA step: filt + ((raw - filt) >>> ALPHA_SHIFT),
// clamped to the 10-bit coordinate range.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module corner_ema
  import corner_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  coord_t filt_i,
  input  coord_t raw_i,
  output coord_t filt_o
);

  logic signed [11:0] w_diff;
  logic signed [11:0] w_step;
  logic signed [11:0] w_sum;

  assign w_diff = $signed({2'b00, raw_i}) - $signed({2'b00, filt_i});
  assign w_step = w_diff >>> ALPHA_SHIFT;
  assign w_sum  = $signed({2'b00, filt_i}) + w_step;

  always_comb begin
    filt_o = w_sum[9:0];
    if (w_sum[11]) begin
      filt_o = '0;
    end else if (w_sum > 12'sd1023) begin
      filt_o = 10'd1023;
    end
  end

endmodule

`default_nettype wire

// File: rtl/corner_tracker.sv
// ============================================================================
// Module : corner_tracker
// Per-frame marker corner capture, plausibility check, acquire/track/lost
// control and EMA smoothing with a valid/ready result port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module corner_tracker
  import corner_pkg::*;
#(
  parameter int MIN_SIZE    = 16,
  parameter int MAX_JUMP    = 40,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 4,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             VGA_VS,
  input  coord_t           tl_x,
  input  coord_t           tl_y,
  input  coord_t           tr_x,
  input  coord_t           tr_y,
  input  coord_t           bl_x,
  input  coord_t           bl_y,
  input  coord_t           br_x,
  input  coord_t           br_y,
  corner_tracker_if.master out_if,
  output logic [1:0]       track_state,
  output logic             overrun
);

  localparam logic signed [10:0] MIN_S = 11'(MIN_SIZE);
  localparam logic signed [10:0] MAX_J = 11'(MAX_JUMP);

  coord_t       raw_in [NUM_COORDS];
  coord_t       raw_q  [NUM_COORDS];
  coord_t       raw_d  [NUM_COORDS];
  coord_t       prev_q [NUM_COORDS];
  coord_t       prev_d [NUM_COORDS];
  coord_t       filt_q [NUM_COORDS];
  coord_t       filt_d [NUM_COORDS];
  coord_t       out_q  [NUM_COORDS];
  coord_t       out_d  [NUM_COORDS];

  fsm_state_e   state_q, state_d;
  track_state_e trk_q, trk_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   hit_q, hit_d;
  logic [7:0]   miss_q, miss_d;
  logic         vs_prev_q;
  logic         first_q, first_d;
  logic         apply_q, apply_d;
  logic         load_q, load_d;
  logic         out_valid_q, out_valid_d;
  logic         overrun_q, overrun_d;

  logic              w_vs_fall;
  logic signed [10:0] w_width;
  logic signed [10:0] w_height;
  logic              w_plausible;
  logic [NUM_COORDS-1:0] w_jump_ok;
  logic              w_skip_jump;
  logic              w_good;
  coord_t            w_ema;

  assign raw_in[IDX_TL_X] = tl_x;
  assign raw_in[IDX_TL_Y] = tl_y;
  assign raw_in[IDX_TR_X] = tr_x;
  assign raw_in[IDX_TR_Y] = tr_y;
  assign raw_in[IDX_BL_X] = bl_x;
  assign raw_in[IDX_BL_Y] = bl_y;
  assign raw_in[IDX_BR_X] = br_x;
  assign raw_in[IDX_BR_Y] = br_y;

  assign w_vs_fall = vs_prev_q && !VGA_VS;

  assign w_width     = $signed({1'b0, raw_q[IDX_BR_X]}) - $signed({1'b0, raw_q[IDX_TL_X]});
  assign w_height    = $signed({1'b0, raw_q[IDX_BL_Y]}) - $signed({1'b0, raw_q[IDX_TR_Y]});
  assign w_plausible = (w_width >= MIN_S) && (w_height >= MIN_S);

  // Jump reference is the smoothed estimate while tracking, else the last raw frame.
  for (genvar i = 0; i < NUM_COORDS; i++) begin : g_jump
    coord_t             w_ref;
    logic signed [10:0] w_delta;
    assign w_ref        = (trk_q == TRK_TRACK) ? filt_q[i] : prev_q[i];
    assign w_delta      = $signed({1'b0, raw_q[i]}) - $signed({1'b0, w_ref});
    assign w_jump_ok[i] = (w_delta <= MAX_J) && (w_delta >= -MAX_J);
  end

  assign w_skip_jump = (trk_q == TRK_SEARCH) && first_q;
  assign w_good      = w_plausible && (w_skip_jump || (&w_jump_ok));

  corner_ema #(
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_ema (
    .filt_i (filt_q[idx_q]),
    .raw_i  (raw_q[idx_q]),
    .filt_o (w_ema)
  );

  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    first_d = first_q;
    apply_d = apply_q;
    load_d  = 1'b0;
    raw_d   = raw_q;
    prev_d  = prev_q;
    filt_d  = filt_q;

    unique case (state_q)
      ST_WAIT: begin
        if (w_vs_fall) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        raw_d   = raw_in;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_FILTER;
        idx_d   = '0;
        apply_d = 1'b0;
        prev_d  = raw_q;
        if (trk_q == TRK_SEARCH) begin
          first_d = 1'b0;
          if (w_good) begin
            hit_d = hit_q + 8'd1;
            if (hit_q + 8'd1 >= 8'(ACQ_FRAMES)) begin
              filt_d = raw_q;
              miss_d = '0;
              trk_d  = TRK_TRACK;
            end
          end else begin
            hit_d = '0;
          end
        end else begin
          if (w_good) begin
            miss_d  = '0;
            apply_d = 1'b1;
          end else begin
            miss_d = miss_q + 8'd1;
            if (miss_q + 8'd1 >= 8'(LOST_FRAMES)) begin
              filt_d  = '{default: '0};
              hit_d   = '0;
              trk_d   = TRK_SEARCH;
              first_d = 1'b1;
            end
          end
        end
      end
      ST_FILTER: begin
        if (apply_q) filt_d[idx_q] = w_ema;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = ST_WAIT;
          load_d  = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // A fresh load always wins over a simultaneous acceptance.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    if (load_q) begin
      out_d       = filt_q;
      out_valid_d = 1'b1;
      overrun_d   = out_valid_q && !out_if.out_ready;
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_WAIT;
      trk_q       <= TRK_SEARCH;
      idx_q       <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      vs_prev_q   <= 1'b0;
      first_q     <= 1'b1;
      apply_q     <= 1'b0;
      load_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      raw_q       <= '{default: '0};
      prev_q      <= '{default: '0};
      filt_q      <= '{default: '0};
      out_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      trk_q       <= trk_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      vs_prev_q   <= VGA_VS;
      first_q     <= first_d;
      apply_q     <= apply_d;
      load_q      <= load_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      filt_q      <= filt_d;
      out_q       <= out_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.f_tl_x    = out_q[IDX_TL_X];
  assign out_if.f_tl_y    = out_q[IDX_TL_Y];
  assign out_if.f_tr_x    = out_q[IDX_TR_X];
  assign out_if.f_tr_y    = out_q[IDX_TR_Y];
  assign out_if.f_bl_x    = out_q[IDX_BL_X];
  assign out_if.f_bl_y    = out_q[IDX_BL_Y];
  assign out_if.f_br_x    = out_q[IDX_BR_X];
  assign out_if.f_br_y    = out_q[IDX_BR_Y];
  assign track_state      = trk_q;
  assign overrun          = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_corner_tracker.sv
// ============================================================================
// Module : tb_corner_tracker
// Self-checking bench for corner_tracker against a frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_corner_tracker;

  localparam int MIN_SIZE    = 16;
  localparam int MAX_JUMP    = 40;
  localparam int ACQ_FRAMES  = 3;
  localparam int LOST_FRAMES = 4;
  localparam int ALPHA_SHIFT = 2;

  logic       clk;
  logic       reset;
  logic       VGA_VS;
  logic [9:0] stim [8];
  logic [1:0] track_state;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: one update per frame, straight from the frame rules.
  bit m_track;
  bit m_first;
  bit m_pending;
  int m_hit;
  int m_miss;
  int m_filt [8];
  int m_prev [8];

  corner_tracker_if u_if ();

  corner_tracker #(
    .MIN_SIZE    (MIN_SIZE),
    .MAX_JUMP    (MAX_JUMP),
    .ACQ_FRAMES  (ACQ_FRAMES),
    .LOST_FRAMES (LOST_FRAMES),
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .VGA_VS      (VGA_VS),
    .tl_x        (stim[0]),
    .tl_y        (stim[1]),
    .tr_x        (stim[2]),
    .tr_y        (stim[3]),
    .bl_x        (stim[4]),
    .bl_y        (stim[5]),
    .br_x        (stim[6]),
    .br_y        (stim[7]),
    .out_if      (u_if.master),
    .track_state (track_state),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] dut_outputs();
    return {u_if.f_tl_x, u_if.f_tl_y, u_if.f_tr_x, u_if.f_tr_y,
            u_if.f_bl_x, u_if.f_bl_y, u_if.f_br_x, u_if.f_br_y};
  endfunction

  function automatic logic [79:0] model_outputs();
    logic [79:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[79-10*i -: 10] = 10'(m_filt[i]);
    return v;
  endfunction

  // alpha = 1/2^ALPHA_SHIFT, rounding toward minus infinity, clamped to 0..1023
  function automatic int ema_ref(input int f, input int r);
    int d, den, step, res;
    den  = 1 << ALPHA_SHIFT;
    d    = r - f;
    step = (d >= 0) ? d / den : -((-d + den - 1) / den);
    res  = f + step;
    if (res < 0) res = 0;
    if (res > 1023) res = 1023;
    return res;
  endfunction

  task automatic model_reset();
    m_track = 0; m_first = 1; m_pending = 0; m_hit = 0; m_miss = 0;
    for (int i = 0; i < 8; i++) begin m_filt[i] = 0; m_prev[i] = 0; end
  endtask

  task automatic model_frame();
    bit plaus, jump_ok, good;
    int r, d;
    plaus = (int'(stim[6]) - int'(stim[0]) >= MIN_SIZE) &&
            (int'(stim[5]) - int'(stim[3]) >= MIN_SIZE);
    jump_ok = 1;
    for (int i = 0; i < 8; i++) begin
      r = m_track ? m_filt[i] : m_prev[i];
      d = int'(stim[i]) - r;
      if (d > MAX_JUMP || d < -MAX_JUMP) jump_ok = 0;
    end
    if (!m_track && m_first) jump_ok = 1;
    good = plaus && jump_ok;
    if (!m_track) begin
      m_first = 0;
      if (good) begin
        m_hit++;
        if (m_hit >= ACQ_FRAMES) begin
          m_track = 1; m_miss = 0;
          for (int i = 0; i < 8; i++) m_filt[i] = int'(stim[i]);
        end
      end else begin
        m_hit = 0;
      end
    end else if (good) begin
      m_miss = 0;
      for (int i = 0; i < 8; i++) m_filt[i] = ema_ref(m_filt[i], int'(stim[i]));
    end else begin
      m_miss++;
      if (m_miss >= LOST_FRAMES) begin
        m_track = 0; m_hit = 0; m_first = 1;
        for (int i = 0; i < 8; i++) m_filt[i] = 0;
      end
    end
    for (int i = 0; i < 8; i++) m_prev[i] = int'(stim[i]);
  endtask

  task automatic set_quad(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy, input int dx, input int dy);
    stim[0] = 10'(ax); stim[1] = 10'(ay); stim[2] = 10'(bx); stim[3] = 10'(by);
    stim[4] = 10'(cx); stim[5] = 10'(cy); stim[6] = 10'(dx); stim[7] = 10'(dy);
  endtask

  // mode 0: ready held high; 1: ready held low; 2: ready rises on the load cycle
  task automatic run_frame(input int mode);
    bit exp_ovr;
    @(negedge clk);
    VGA_VS = 1'b1;
    u_if.out_ready = (mode == 0);
    repeat (2) @(negedge clk);
    VGA_VS = 1'b0;
    @(posedge clk);
    model_frame();
    repeat (2) @(posedge clk);
    #1 check_value("track_e2", 80'(track_state), 80'(m_track));
    repeat (8) @(posedge clk);
    #1 if (mode == 2) u_if.out_ready = 1'b1;
    if (mode == 0) m_pending = 0;
    exp_ovr = m_pending && (mode == 1);
    @(posedge clk);
    #1;
    check_value("outputs", dut_outputs(), model_outputs());
    check_value("valid_load", 80'(u_if.out_valid), 80'd1);
    check_value("overrun_load", 80'(overrun), 80'(exp_ovr));
    @(posedge clk);
    #1;
    m_pending = (mode == 1);
    check_value("valid_after", 80'(u_if.out_valid), 80'(m_pending));
    check_value("overrun_after", 80'(overrun), 80'd0);
    VGA_VS = 1'b1;
  endtask

  initial begin
    int bx, by, sz, kind, j;
    reset = 1'b0;
    VGA_VS = 1'b0;
    u_if.out_ready = 1'b0;
    set_quad(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_valid", 80'(u_if.out_valid), 80'd0);
    check_value("rst_overrun", 80'(overrun), 80'd0);
    check_value("rst_track", 80'(track_state), 80'd0);
    check_value("rst_outputs", dut_outputs(), 80'd0);
    @(negedge clk);
    reset = 1'b1;

    // Acquisition on a stable square
    set_quad(100, 100, 200, 100, 100, 200, 200, 200);
    repeat (3) run_frame(0);
    check_value("acq_track", 80'(track_state), 80'd1);
    check_value("acq_tl_x", 80'(u_if.f_tl_x), 80'd100);

    // EMA up then down
    stim[0] = 10'd120; run_frame(0);
    check_value("ema_up", 80'(u_if.f_tl_x), 80'd105);
    stim[0] = 10'd90;  run_frame(0);
    check_value("ema_down", 80'(u_if.f_tl_x), 80'd101);

    // Jump reject, loss, reacquire
    stim[0] = 10'd150;
    repeat (4) run_frame(0);
    check_value("lost_track", 80'(track_state), 80'd0);
    check_value("lost_outputs", dut_outputs(), 80'd0);
    repeat (3) run_frame(0);
    check_value("reacq_track", 80'(track_state), 80'd1);

    // Degenerate quads in TRACK
    set_quad(0, 0, 0, 0, 0, 0, 0, 0);                    run_frame(0);
    set_quad(150, 100, 200, 100, 100, 200, 165, 200);    run_frame(0);
    check_value("deg_hold_br_x", 80'(u_if.f_br_x), 80'd200);
    stim[6] = 10'd166;                                   run_frame(0);
    check_value("deg_accept_br_x", 80'(u_if.f_br_x), 80'd191);

    // Handshake: overrun, then load coinciding with acceptance
    run_frame(1);
    run_frame(1);
    run_frame(2);
    run_frame(0);

    // Randomized frames around a drifting quad
    bx = 300; by = 300; sz = 120;
    for (int f = 0; f < 50; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        set_quad(0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        if (kind == 1) begin
          bx = int'($urandom_range(50, 700));
          by = int'($urandom_range(50, 700));
          sz = int'($urandom_range(16, 250));
        end
        j = int'($urandom_range(0, 20)) - 10;
        set_quad(bx + j, by - j, bx + sz + j, by + j, bx - j, by + sz + j, bx + sz - j, by + sz - j);
      end
      run_frame(int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of FILTER
    @(negedge clk);
    VGA_VS = 1'b1;
    u_if.out_ready = 1'b1;
    set_quad(100, 100, 200, 100, 100, 200, 200, 200);
    repeat (2) @(negedge clk);
    VGA_VS = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_value("arst_valid", 80'(u_if.out_valid), 80'd0);
    check_value("arst_track", 80'(track_state), 80'd0);
    check_value("arst_outputs", dut_outputs(), 80'd0);
    check_value("arst_overrun", 80'(overrun), 80'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_frame(0);
    check_value("post_rst_search", 80'(track_state), 80'd0);
    repeat (2) run_frame(0);
    check_value("post_rst_acq", 80'(track_state), 80'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
